// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for the EXE stage (DIV / DIVU).
// One quotient bit per cycle; result (Q to LO, R to HI) is registered on entry to DONE.
module div_iter_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_DivStart,
  input  logic             EXE_DivSigned,
  input  logic [WIDTH-1:0] EXE_BusA,
  input  logic [WIDTH-1:0] EXE_BusB,
  input  logic             EXE_DivFlush,
  output logic             Div_Busy,
  output logic             Div_Done,
  output logic [WIDTH-1:0] Div_Quotient,
  output logic [WIDTH-1:0] Div_Remainder
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dmag_q, dmag_d, araw_q, araw_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic             sgnq_q, sgnq_d, sgnr_q, sgnr_d;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, dvd_nx, q_fix, r_fix;
  logic             accept, a_neg, b_neg;

  assign accept = (state_q == IDLE) && EXE_DivStart && !EXE_DivFlush;
  assign a_neg  = EXE_DivSigned && EXE_BusA[WIDTH-1];
  assign b_neg  = EXE_DivSigned && EXE_BusB[WIDTH-1];

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dmag_q};
  assign rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign dvd_nx = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
  assign q_fix  = sgnq_q ? -dvd_nx : dvd_nx;
  assign r_fix  = sgnr_q ? -rem_nx : rem_nx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dmag_d  = dmag_q;
    araw_d  = araw_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = a_neg ? -EXE_BusA : EXE_BusA;
          dmag_d  = b_neg ? -EXE_BusB : EXE_BusB;
          araw_d  = EXE_BusA;
          sgnq_d  = a_neg ^ b_neg;
          sgnr_d  = a_neg;
        end
      end
      RUN: begin
        if (EXE_DivFlush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          dvd_d = dvd_nx;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            // Divide by zero bypasses the sign fixup and returns the raw dividend.
            if (dmag_q == '0) begin
              quot_d = '1;
              remo_d = araw_q;
            end else begin
              quot_d = q_fix;
              remo_d = r_fix;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dmag_q  <= '0;
      araw_q  <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dmag_q  <= dmag_d;
      araw_q  <= araw_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign Div_Busy      = rst && (accept || (state_q == RUN));
  assign Div_Done      = (state_q == DONE) && !EXE_DivFlush;
  assign Div_Quotient  = quot_q;
  assign Div_Remainder = remo_q;
endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit: timeline/arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_div_iter_unit;
  localparam int W = 32;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0, flush = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [W-1:0] q, r;

  int total = 0, bad = 0, cyc = 0;
  int done_cyc = -1, done_cnt = 0;
  logic [W-1:0] done_q, done_r;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .EXE_DivStart(start), .EXE_DivSigned(sgn),
    .EXE_BusA(a), .EXE_BusB(b), .EXE_DivFlush(flush),
    .Div_Busy(busy), .Div_Done(done),
    .Div_Quotient(q), .Div_Remainder(r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: 64-bit signed division avoids the 0x80000000/-1 overflow.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint sx, sy, qq, rr;
    if (y == '0) return {{W{1'b1}}, x};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'(x);
      sy = longint'(y);
    end
    qq = sx / sy;
    rr = sx % sy;
    return {qq[W-1:0], rr[W-1:0]};
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a divide accepted in cycle c keeps Busy high through c+W and pulses Done at c+W+1.
  logic [W-1:0] held_q = '0, held_r = '0, pend_q = '0, pend_r = '0;
  int done_at = -1;
  always @(negedge clk) begin
    logic acc, run, dexp;
    if (!rst) begin
      done_at = -1;
      held_q  = '0;
      held_r  = '0;
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_q", q, held_q);
      check("rst_r", r, held_r);
    end else begin
      run  = (done_at >= 0) && (cyc < done_at);
      acc  = (done_at < 0) && start && !flush;
      dexp = (done_at >= 0) && (cyc == done_at) && !flush;
      if ((done_at >= 0) && (cyc == done_at)) begin
        held_q = pend_q;
        held_r = pend_r;
      end
      check("busy", W'(busy), W'(acc || run));
      check("done", W'(done), W'(dexp));
      check("quot", q, held_q);
      check("rem", r, held_r);
      check("busy_done_excl", W'(busy && done), '0);
      if (done) begin
        done_cyc = cyc;
        done_q   = q;
        done_r   = r;
        done_cnt++;
      end
      if (acc) begin
        {pend_q, pend_r} = ref_div(a, b, sgn);
        done_at = cyc + W + 1;
      end else if (run && flush) begin
        done_at = -1;
      end else if ((done_at >= 0) && (cyc == done_at)) begin
        done_at = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    start = 1'b1; a = x; b = y; sgn = s;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int n0);
    for (int i = 0; i < W + 10 && done_cnt == n0; i++) step();
    total++;
    if (done_cnt == n0) begin
      bad++;
      $display("FAIL %s: no Done within bound (got none, want one)", nm);
    end
  endtask

  task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er);
    int c0, n0;
    n0 = done_cnt;
    c0 = cyc;
    issue(x, y, s);
    wait_done(nm, n0);
    if (done_cnt != n0) begin
      check({nm, "_lat"}, W'(done_cyc - c0), W'(W + 1));
      check({nm, "_q"}, done_q, eq);
      check({nm, "_r"}, done_r, er);
    end
    $display("op %s a=%h b=%h s=%0d -> q=%h r=%h", nm, x, y, s, done_q, done_r);
    step();
  endtask

  initial begin
    int n0, c0;
    #2 rst = 1'b0;
    step(); step();
    check("reset_q_literal", q, '0);
    rst = 1'b1;
    step();

    directed("divu_7_2",   32'd7,        32'd2,        1'b0, 32'h3,        32'h1);
    directed("div_m7_2",   32'hFFFFFFF9, 32'h2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    directed("div_7_m2",   32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h1);
    directed("div_ovf",    32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0);
    directed("divu_max_1", 32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFF, 32'h0);
    directed("div_m100_7", 32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
    directed("div_m5_0",   32'hFFFFFFFB, 32'h0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB);
    directed("divu_z",     32'h1234,     32'h0,        1'b0, 32'hFFFFFFFF, 32'h1234);

    // Flush on the 10th RUN cycle: no Done, outputs keep the divide-by-zero result.
    n0 = done_cnt;
    issue(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    directed("after_flush", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    check("flush_no_extra_done", W'(done_cnt - n0), W'(1));

    // Start together with flush in IDLE is dropped.
    n0 = done_cnt;
    start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd3;
    step();
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < W + 4; i++) step();
    check("flush_start_dropped", W'(done_cnt - n0), '0);
    check("flush_start_q_kept", q, 32'd14);

    // Asynchronous reset during RUN clears outputs at once and cancels the divide.
    n0 = done_cnt;
    issue(32'd50, 32'd3, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    #1;
    check("async_rst_q", q, '0);
    check("async_rst_r", r, '0);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < W + 4; i++) step();
    check("rst_no_done", W'(done_cnt - n0), '0);

    // Start held through the DONE cycle: ignored there, accepted the next cycle.
    n0 = done_cnt;
    c0 = cyc;
    issue(32'd1000, 32'd9, 1'b0);
    for (int i = 0; i < W; i++) step();
    start = 1'b1; a = 32'hFFFFFC18; b = 32'd10; sgn = 1'b1;
    step();
    check("b2b_first_done", W'(done_cyc - c0), W'(W + 1));
    check("b2b_first_q", done_q, 32'd111);
    check("b2b_first_r", done_r, 32'd1);
    step();
    start = 1'b0;
    wait_done("b2b_second", n0 + 1);
    check("b2b_second_lat", W'(done_cyc - c0), W'(2 * W + 3));
    check("b2b_second_q", done_q, 32'hFFFFFF9C);
    check("b2b_second_r", done_r, 32'h0);
    $display("op b2b -> q=%h r=%h", done_q, done_r);
    step();

    // Randomized operations, occasional flushes and zero/small divisors.
    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] x, y;
      int fat, gap;
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = W'($urandom_range(1, 15));
        2: y = -W'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      fat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, W) : -1;
      issue(x, y, 1'($urandom_range(0, 1)));
      for (int i = 0; i <= W; i++) begin
        flush = (i == fat);
        step();
      end
      flush = 1'b0;
      $display("op rnd%0d a=%h b=%h flush_at=%0d -> q=%h r=%h", n, x, y, fat, q, r);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) step();
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
